// File: rtl/word_lexer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : word_lexer_pkg
//  Purpose  : Shared token kinds, match-FSM state encoding and keyword bytes
//             for the word_lexer block, plus small keyword-matching helpers.
//  Revision : 1.0  initial release
// ============================================================================
package word_lexer_pkg;

   // Token kind presented on tok_kind; TOK_NONE whenever no token is valid.
   typedef enum logic [1:0] {
      TOK_NONE  = 2'b00,
      TOK_BEGIN = 2'b01,
      TOK_END   = 2'b10,
      TOK_OTHER = 2'b11
   } tok_kind_e;

   // Match FSM: Bk / Ek mean the first k characters of the keyword matched.
   typedef enum logic [3:0] {
      IDLE = 4'd0,
      B1   = 4'd1,
      B2   = 4'd2,
      B3   = 4'd3,
      B4   = 4'd4,
      B5   = 4'd5,
      E1   = 4'd6,
      E2   = 4'd7,
      E3   = 4'd8,
      OTH  = 4'd9
   } lex_state_e;

   // Lowercase keyword bytes for "begin".
   localparam logic [7:0] KW_BEGIN_0 = 8'h62;  // b
   localparam logic [7:0] KW_BEGIN_1 = 8'h65;  // e
   localparam logic [7:0] KW_BEGIN_2 = 8'h67;  // g
   localparam logic [7:0] KW_BEGIN_3 = 8'h69;  // i
   localparam logic [7:0] KW_BEGIN_4 = 8'h6e;  // n

   // Lowercase keyword bytes for "end".
   localparam logic [7:0] KW_END_0   = 8'h65;  // e
   localparam logic [7:0] KW_END_1   = 8'h6e;  // n
   localparam logic [7:0] KW_END_2   = 8'h64;  // d

   // Advance the match FSM by one (already lowercased) word character.
   // Anything that breaks a keyword prefix, or extends a complete keyword,
   // lands in OTH, which is absorbing for the rest of the word.
   function automatic lex_state_e lex_next(input lex_state_e st, input logic [7:0] ch);
      lex_state_e nxt;
      nxt = OTH;
      case (st)
         IDLE: begin
            if (ch == KW_BEGIN_0)
               nxt = B1;
            else if (ch == KW_END_0)
               nxt = E1;
         end
         B1:      if (ch == KW_BEGIN_1) nxt = B2;
         B2:      if (ch == KW_BEGIN_2) nxt = B3;
         B3:      if (ch == KW_BEGIN_3) nxt = B4;
         B4:      if (ch == KW_BEGIN_4) nxt = B5;
         E1:      if (ch == KW_END_1)   nxt = E2;
         E2:      if (ch == KW_END_2)   nxt = E3;
         default: nxt = OTH;
      endcase
      return nxt;
   endfunction

   // Token kind for a word that terminates while the FSM is in state st.
   function automatic tok_kind_e kind_of(input lex_state_e st);
      tok_kind_e k;
      case (st)
         B5:      k = TOK_BEGIN;
         E3:      k = TOK_END;
         default: k = TOK_OTHER;
      endcase
      return k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/word_lexer_char_class.sv
`default_nettype none
// ============================================================================
//  Module   : char_class
//  Purpose  : Combinational byte classifier: folds ASCII uppercase letters
//             to lowercase and flags the configured delimiter byte.
//  Revision : 1.0  initial release
// ============================================================================
module char_class #(
   parameter logic [7:0] DELIM = 8'h20
) (
   input  logic [7:0] ch,
   output logic [7:0] ch_lower,
   output logic       is_delim
);

   // Fold 'A'..'Z' onto 'a'..'z'; every other byte passes through untouched.
   always_comb begin
      ch_lower = ch;
      if ((ch >= 8'h41) && (ch <= 8'h5a))
         ch_lower = ch | 8'h20;
      is_delim = (ch == DELIM);
   end

endmodule
`default_nettype wire

// File: rtl/word_lexer.sv
`default_nettype none
// ============================================================================
//  Module   : word_lexer
//  Purpose  : Splits a byte-per-cycle ASCII stream into delimiter-separated
//             words and emits one registered token (BEGIN / END / OTHER,
//             case-insensitive) with a saturating length per completed word.
//  Options  : WORD_LEXER_WCNT_EN - adds a 16-bit wrapping emitted-word
//             counter on output word_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module word_lexer
   import word_lexer_pkg::*;
#(
   parameter logic [7:0] DELIM = 8'h20,
   parameter int         LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in,
   input  logic             flush,
   output logic             tok_valid,
   output logic [1:0]       tok_kind,
   output logic [LEN_W-1:0] tok_len
`ifdef WORD_LEXER_WCNT_EN
   ,
   output logic [15:0]      word_cnt
`endif
);

   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   logic [7:0]       ch_lower;
   logic             is_delim;

   lex_state_e       state;
   lex_state_e       state_nxt;
   lex_state_e       char_state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_nxt;
   logic [LEN_W-1:0] char_len;
   logic             term;
   logic             emit_nxt;
   tok_kind_e        kind_nxt;
   logic [LEN_W-1:0] emit_len_nxt;

   char_class #(
      .DELIM (DELIM)
   ) u_char_class (
      .ch       (in),
      .ch_lower (ch_lower),
      .is_delim (is_delim)
   );

   // Next state: first absorb an accepted word character, then terminate the
   // word if a delimiter or flush arrived, so a char+flush joins the word.
   always_comb begin
      char_state   = state;
      char_len     = len;
      state_nxt    = state;
      len_nxt      = len;
      emit_nxt     = 1'b0;
      kind_nxt     = TOK_NONE;
      emit_len_nxt = '0;

      if (in_valid && !is_delim) begin
         char_state = lex_next(state, ch_lower);
         if (len != LEN_MAX)
            char_len = len + LEN_ONE;
      end

      term = flush | (in_valid & is_delim);

      state_nxt = char_state;
      len_nxt   = char_len;

      if (term) begin
         state_nxt = IDLE;
         len_nxt   = '0;
         // IDLE means no word characters were seen: nothing to report.
         if (char_state != IDLE) begin
            emit_nxt     = 1'b1;
            kind_nxt     = kind_of(char_state);
            emit_len_nxt = char_len;
         end
      end
   end

   // Match state, running length and the registered token outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         len       <= '0;
         tok_valid <= 1'b0;
         tok_kind  <= TOK_NONE;
         tok_len   <= '0;
      end else begin
         state     <= state_nxt;
         len       <= len_nxt;
         tok_valid <= emit_nxt;
         tok_kind  <= kind_nxt;
         tok_len   <= emit_len_nxt;
      end
   end

`ifdef WORD_LEXER_WCNT_EN
   // Emitted-word counter; steps on the same edge that raises tok_valid.
   always_ff @(posedge clk) begin
      if (!reset)
         word_cnt <= '0;
      else if (emit_nxt)
         word_cnt <= word_cnt + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_lexer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_lexer
//  Purpose  : Self-checking bench for word_lexer: directed word sequences
//             followed by randomized traffic, compared cycle by cycle with a
//             word-buffer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_word_lexer;

   localparam int LEN_W = 8;
   localparam int SPACE = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_ch = 8'h00;
   logic             flush = 1'b0;
   logic             tok_valid;
   logic [1:0]       tok_kind;
   logic [LEN_W-1:0] tok_len;
`ifdef WORD_LEXER_WCNT_EN
   logic [15:0]      word_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: the pending word as a queue of lowercase bytes.
   byte unsigned word_q[$];
   int           exp_valid;
   int           exp_kind;
   int           exp_len;
   int           exp_cnt;

   word_lexer #(
      .DELIM (8'h20),
      .LEN_W (LEN_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in        (in_ch),
      .flush     (flush),
      .tok_valid (tok_valid),
      .tok_kind  (tok_kind),
      .tok_len   (tok_len)
`ifdef WORD_LEXER_WCNT_EN
      ,
      .word_cnt  (word_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic byte unsigned to_lower(input byte unsigned c);
      if (c >= 65 && c <= 90)
         return byte'(c + 8'd32);
      return c;
   endfunction

   function automatic bit word_is(input string kw);
      if (word_q.size() != kw.len())
         return 1'b0;
      for (int i = 0; i < kw.len(); i++)
         if (word_q[i] != kw[i])
            return 1'b0;
      return 1'b1;
   endfunction

   // Apply the sampled inputs of one clock edge to the reference model.
   task automatic model_edge(input logic v, input byte unsigned c, input logic f, input logic r);
      exp_valid = 0;
      exp_kind  = 0;
      exp_len   = 0;
      if (!r) begin
         word_q.delete();
         exp_cnt = 0;
      end else begin
         if (v && c != SPACE)
            word_q.push_back(to_lower(c));
         if (f || (v && c == SPACE)) begin
            if (word_q.size() > 0) begin
               exp_valid = 1;
               exp_len   = (word_q.size() > 255) ? 255 : word_q.size();
               if (word_is("begin"))
                  exp_kind = 1;
               else if (word_is("end"))
                  exp_kind = 2;
               else
                  exp_kind = 3;
               exp_cnt = (exp_cnt + 1) % 65536;
            end
            word_q.delete();
         end
      end
   endtask

   // One clock cycle: drive, let the edge happen, then compare away from it.
   task automatic step(input logic v, input byte unsigned c, input logic f, input logic r);
      in_valid = v;
      in_ch    = c;
      flush    = f;
      reset    = r;
      @(posedge clk);
      #1;
      model_edge(v, c, f, r);
      check("tok_valid", 32'(tok_valid), 32'(exp_valid));
      check("tok_kind",  32'(tok_kind),  32'(exp_kind));
      check("tok_len",   32'(tok_len),   32'(exp_len));
`ifdef WORD_LEXER_WCNT_EN
      check("word_cnt",  32'(word_cnt),  32'(exp_cnt));
`endif
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++)
         step(1'b1, s[i], 1'b0, 1'b1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
   endtask

   initial begin
      string kws[6];
      kws[0] = "begin"; kws[1] = "end"; kws[2] = "BEGIN";
      kws[3] = "eNd";   kws[4] = "beg"; kws[5] = "endd";
      exp_valid = 0; exp_kind = 0; exp_len = 0; exp_cnt = 0;

      // Reset values.
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      send_str("BEGIN end ");
      idle_cycles(2);
      send_str("  bEgIn   ");
      send_str("begins ends en x ");

      // Flush in the same cycle as the last character, then a lone space.
      send_str("en");
      step(1'b1, 8'h64, 1'b1, 1'b1);
      step(1'b1, 8'h20, 1'b0, 1'b1);

      // Delimiter plus flush together, and flush while idle.
      send_str("foo");
      step(1'b1, 8'h20, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);

      // Reset mid-word drops the pending word.
      send_str("beg");
      step(1'b0, 8'h00, 1'b0, 1'b0);
      send_str("end ");

      // Length saturation.
      for (int i = 0; i < 300; i++)
         step(1'b1, 8'h61, 1'b0, 1'b1);
      step(1'b1, 8'h20, 1'b0, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         int sel;
         byte unsigned c;
         sel = $urandom_range(0, 99);
         if (sel < 4) begin
            string w;
            w = kws[$urandom_range(0, 5)];
            send_str(w);
         end else begin
            if (sel < 60) begin
               string alpha;
               alpha = "bBeEgGiInNdDxA";
               c = alpha[$urandom_range(0, alpha.len() - 1)];
            end else if (sel < 85) begin
               c = 8'h20;
            end else begin
               c = 8'($urandom_range(0, 255));
            end
            step(($urandom_range(0, 9) != 0), c,
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 249) != 0));
         end
      end
      step(1'b0, 8'h00, 1'b1, 1'b1);
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/word_lexer.md
# word_lexer

- Upstream of the begin/end balance checker.
- Consumes a byte-per-cycle ASCII stream.
- Splits the stream into space-delimited words.
- Emits one classified token per completed word: BEGIN, END or OTHER, matched case-insensitively, with the word length.
- The checker only counts tokens. All character-level matching lives here.

## Interface
- DELIM, default 8'h20: word delimiter byte.
- LEN_W, default 8: width of the word-length field; length saturates at 2^LEN_W-1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  `in` carries a character this cycle.
- in  in  8  ASCII character.
- flush  in  1  end-of-stream pulse; terminates the pending word.
- tok_valid  out  1  one-cycle pulse; token fields valid.
- tok_kind  out  2  01 BEGIN, 10 END, 11 OTHER; 00 whenever tok_valid=0.
- tok_len  out  LEN_W  character count of the emitted word.

## Operation
- Character classification:
  - Bytes 0x41–0x5A are folded to lowercase (|0x20).
  - All other bytes are used unchanged.
  - Only DELIM is a delimiter. Every other byte is a word character.
- Match FSM states: IDLE, B1, B2, B3, B4, B5, E1, E2, E3, OTH.
  - B1..B5 mean the prefix "b".."begin" has been matched. E1..E3 mean "e".."end" has been matched.
  - IDLE + 'b' -> B1. IDLE + 'e' -> E1. IDLE + any other word char -> OTH.
  - Bk + next char of "begin" -> Bk+1. Ek + next char of "end" -> Ek+1.
  - Any other word char from any non-IDLE state -> OTH, including a char after B5 or E3.
  - OTH absorbs every word char.
- Word termination happens on an accepted DELIM or on flush.
  - If state is not IDLE, register a token: B5 -> BEGIN, E3 -> END, all other states -> OTHER.
  - tok_len is the number of word chars seen. It saturates and does not wrap.
  - After termination: state -> IDLE, length -> 0.
- A delimiter or flush while in IDLE emits nothing. Consecutive spaces produce no empty tokens.
- flush and in_valid in the same cycle:
  - The character is consumed first, then the word is terminated.
  - A word char therefore becomes part of the flushed word.
  - A DELIM plus flush emits at most one token.
- Cycles with in_valid=0 and flush=0 hold all state.

## Timing
- Latency: tok_valid is asserted in the cycle after the terminating DELIM or flush is sampled. The outputs are registered.
- tok_valid is high for exactly one cycle per word. Back-to-back words separated by a single space may produce tokens two cycles apart. The minimum spacing is one token per two input cycles.
- There is no backpressure. The downstream stage must accept every pulse.
- Reset values (reset=0 at a clock edge):
  - tok_valid=0, tok_kind=00, tok_len=0.
  - FSM=IDLE, length=0.
  - Any pending word is discarded without a token.
- Reset asserted mid-word drops the word. The first character after reset release starts a new word.

## Configuration
- WORD_LEXER_WCNT_EN defined:
  - Adds output `word_cnt`, 16 bits.
  - word_cnt increments in the same cycle tok_valid rises and wraps at 2^16.
  - It resets to 0.
- WORD_LEXER_WCNT_EN undefined: the port and the counter do not exist. All other behaviour is identical.

## Structure
- Package word_lexer_pkg holds:
  - Token-kind constants: TOK_NONE, TOK_BEGIN, TOK_END, TOK_OTHER.
  - The FSM state encoding.
  - The "begin" and "end" keyword byte constants.
- One combinational sub-module, char_class. It takes the byte and outputs the lowercase byte and is_delim. The top-level instance holds the FSM, length counter and output registers.

## Test plan
- "BEGIN end " (one char per cycle): tok BEGIN len 5 one cycle after the 1st space; tok END len 3 one cycle after the 2nd space.
- "  bEgIn   " with repeated spaces: exactly one token, BEGIN len 5. No tokens for the leading or trailing spaces.
- "begins", "ends", "en", "x" each followed by a space: four OTHER tokens, lengths 6, 4, 2, 1.
- "end" then flush in the same cycle as 'd': tok END len 3 in the next cycle. A following space emits nothing.
- reset=0 mid-word after "beg", then "end ": no token for "beg"; tok END len 3. With WORD_LEXER_WCNT_EN defined, word_cnt=1.
- 300 'a' chars then a space (LEN_W=8): tok OTHER, tok_len=255.
